// File: rtl/qx1_sync_ram.sv
// Single-port synchronous RAM with valid/ready requests, byte strobes and a pipelined read response.
// Optional power-on clear sweep enabled by defining QX1_RAM_CLEAR_ON_RESET_EN.
module qx1_sync_ram #(
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned ADDR_WIDTH   = 16,
  parameter int unsigned DEPTH        = 1 << ADDR_WIDTH,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_we,
  input  logic [ADDR_WIDTH-1:0]     req_addr,
  input  logic [DATA_WIDTH-1:0]     req_wdata,
  input  logic [DATA_WIDTH/8-1:0]   req_wstrb,
  output logic                      rsp_valid,
  output logic [DATA_WIDTH-1:0]     rsp_data,
  output logic                      rsp_err
);

  localparam int unsigned NUM_LANES = DATA_WIDTH / 8;
  localparam int unsigned IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);

`ifdef QX1_RAM_CLEAR_ON_RESET_EN
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
  typedef enum logic [1:0] {ST_RESET = 2'd0, ST_CLEAR = 2'd1, ST_RUN = 2'd2} state_e;
`else
  typedef enum logic [1:0] {ST_RESET = 2'd0, ST_RUN = 2'd2} state_e;
`endif

  state_e state_q, state_d;
  logic   ready_q, ready_d;
`ifdef QX1_RAM_CLEAR_ON_RESET_EN
  logic [IDX_W-1:0] clr_cnt_q, clr_cnt_d;
`endif

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  accept_c;
  logic                  in_range_c;
  logic                  rd_fire_c;
  logic [IDX_W-1:0]      idx_c;
  logic [DATA_WIDTH-1:0] rd_data_c;
  logic                  wr_en_c;
  logic [IDX_W-1:0]      wr_idx_c;
  logic [DATA_WIDTH-1:0] wr_data_c;
  logic [NUM_LANES-1:0]  wr_mask_c;

  logic [READ_LATENCY-1:0] pv_q, pv_d;
  logic [READ_LATENCY-1:0] pe_q, pe_d;
  logic [DATA_WIDTH-1:0]   pd_q [READ_LATENCY];
  logic [DATA_WIDTH-1:0]   pd_d [READ_LATENCY];

  // Control FSM: ready is registered from the next state so it never depends on req_*.
  always_comb begin
    state_d = state_q;
    ready_d = 1'b0;
`ifdef QX1_RAM_CLEAR_ON_RESET_EN
    clr_cnt_d = clr_cnt_q;
`endif
    case (state_q)
      ST_RESET: begin
`ifdef QX1_RAM_CLEAR_ON_RESET_EN
        state_d   = ST_CLEAR;
        clr_cnt_d = '0;
`else
        state_d   = ST_RUN;
`endif
      end
`ifdef QX1_RAM_CLEAR_ON_RESET_EN
      ST_CLEAR: begin
        clr_cnt_d = clr_cnt_q + IDX_W'(1);
        if (clr_cnt_q == LAST_IDX) begin
          state_d = ST_RUN;
        end
      end
`endif
      ST_RUN:   state_d = ST_RUN;
      default:  state_d = ST_RESET;
    endcase
    ready_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_RESET;
      ready_q <= 1'b0;
`ifdef QX1_RAM_CLEAR_ON_RESET_EN
      clr_cnt_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
`ifdef QX1_RAM_CLEAR_ON_RESET_EN
      clr_cnt_q <= clr_cnt_d;
`endif
    end
  end

  // Request decode and the single array write port (shared with the clear sweep).
  always_comb begin
    accept_c   = rst_n & req_valid & ready_q;
    in_range_c = ({1'b0, req_addr} < DEPTH_EXT);
    idx_c      = IDX_W'(req_addr);
    rd_fire_c  = accept_c & ~req_we;
    rd_data_c  = in_range_c ? mem_q[idx_c] : '0;
    wr_en_c    = accept_c & req_we & in_range_c;
    wr_idx_c   = idx_c;
    wr_data_c  = req_wdata;
    wr_mask_c  = req_wstrb;
`ifdef QX1_RAM_CLEAR_ON_RESET_EN
    if (state_q == ST_CLEAR) begin
      wr_en_c   = rst_n;
      wr_idx_c  = clr_cnt_q;
      wr_data_c = '0;
      wr_mask_c = '1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      for (int i = 0; i < int'(NUM_LANES); i++) begin
        if (wr_mask_c[i]) begin
          mem_q[wr_idx_c][8*i +: 8] <= wr_data_c[8*i +: 8];
        end
      end
    end
  end

  // Response pipeline: data only advances behind a valid so the output stage holds its value.
  always_comb begin
    pv_d    = '0;
    pe_d    = '0;
    pv_d[0] = rd_fire_c;
    pe_d[0] = rd_fire_c & ~in_range_c;
    pd_d[0] = rd_fire_c ? rd_data_c : pd_q[0];
    for (int i = 1; i < int'(READ_LATENCY); i++) begin
      pv_d[i] = pv_q[i-1];
      pe_d[i] = pe_q[i-1];
      pd_d[i] = pv_q[i-1] ? pd_q[i-1] : pd_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pv_q <= '0;
      pe_q <= '0;
      for (int i = 0; i < int'(READ_LATENCY); i++) begin
        pd_q[i] <= '0;
      end
    end else begin
      pv_q <= pv_d;
      pe_q <= pe_d;
      for (int i = 0; i < int'(READ_LATENCY); i++) begin
        pd_q[i] <= pd_d[i];
      end
    end
  end

  assign req_ready = ready_q;
  assign rsp_valid = pv_q[READ_LATENCY-1];
  assign rsp_data  = pd_q[READ_LATENCY-1];
  assign rsp_err   = pe_q[READ_LATENCY-1];

endmodule

// File: tb/tb_qx1_sync_ram.sv
// Bench for qx1_sync_ram: array/queue reference model checked every cycle plus directed literal checks.
module tb_qx1_sync_ram;

  localparam int DW      = 16;
  localparam int AW      = 10;
  localparam int DEPTH   = 1000;
  localparam int RL      = 3;
`ifdef QX1_RAM_CLEAR_ON_RESET_EN
  localparam int READY_AFTER = DEPTH + 1;
  localparam int EXP_SWEEP   = 1000;
  localparam logic [15:0] RET_AFTER_RST = 16'h0000;
`else
  localparam int READY_AFTER = 1;
  localparam int EXP_SWEEP   = 0;
  localparam logic [15:0] RET_AFTER_RST = 16'h12EF;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [1:0]    req_wstrb;
  logic          rsp_valid;
  logic [DW-1:0] rsp_data;
  logic          rsp_err;

  qx1_sync_ram #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .READ_LATENCY(RL)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] lane_bits(input logic [1:0] m);
    lane_bits = {{8{m[1]}}, {8{m[0]}}};
  endfunction

  // Reference model: word array with per-lane "known" flags, and a queue of due responses.
  typedef struct {
    int          due;
    logic [15:0] data;
    logic [1:0]  mask;
    logic        err;
  } rsp_t;

  logic [15:0] m_mem   [1024];
  logic [1:0]  m_known [1024];
  rsp_t        exp_q [$];
  int          cyc       = 0;
  int          rel_edges = 0;
  bit          started   = 0;
  logic [15:0] last_data = '0;
  logic [1:0]  last_mask = 2'b11;

  initial begin
    for (int a = 0; a < 1024; a++) begin
      m_mem[a]   = '0;
      m_known[a] = 2'b00;
    end
  end

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      rel_edges = 0;
      exp_q.delete();
      last_data = '0;
      last_mask = 2'b11;
`ifdef QX1_RAM_CLEAR_ON_RESET_EN
      for (int a = 0; a < 1024; a++) begin
        m_mem[a]   = '0;
        m_known[a] = 2'b11;
      end
`endif
    end else begin
      if (req_valid && rel_edges >= READY_AFTER) begin
        if (req_we) begin
          if (int'(req_addr) < DEPTH) begin
            for (int l = 0; l < 2; l++) begin
              if (req_wstrb[l]) begin
                m_mem[req_addr][8*l +: 8] = req_wdata[8*l +: 8];
                m_known[req_addr][l]      = 1'b1;
              end
            end
          end
        end else begin
          rsp_t r;
          r.due = cyc + RL - 1;
          if (int'(req_addr) < DEPTH) begin
            r.data = m_mem[req_addr];
            r.mask = m_known[req_addr];
            r.err  = 1'b0;
          end else begin
            r.data = '0;
            r.mask = 2'b11;
            r.err  = 1'b1;
          end
          exp_q.push_back(r);
        end
      end
      rel_edges++;
    end
    started = 1;
  end

  // Cycle-by-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (started) begin
      bit   exp_v;
      rsp_t r;
      exp_v = (exp_q.size() > 0) && (exp_q[0].due == cyc);
      chk("req_ready", 32'(req_ready), 32'(rel_edges >= READY_AFTER));
      chk("rsp_valid", 32'(rsp_valid), 32'(exp_v));
      if (exp_v) begin
        r = exp_q.pop_front();
        chk("rsp_err", 32'(rsp_err), 32'(r.err));
        chk("rsp_data", 32'(rsp_data & lane_bits(r.mask)), 32'(r.data & lane_bits(r.mask)));
        last_data = r.data;
        last_mask = r.mask;
      end else begin
        chk("rsp_err_idle", 32'(rsp_err), 32'd0);
        chk("rsp_data_hold", 32'(rsp_data & lane_bits(last_mask)), 32'(last_data & lane_bits(last_mask)));
      end
    end
  end

  task automatic issue(input logic we, input int addr, input logic [15:0] wd, input logic [1:0] ws);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = AW'(addr);
    req_wdata = wd;
    req_wstrb = ws;
    @(negedge clk);
  endtask

  task automatic stop();
    req_valid = 1'b0;
  endtask

  task automatic expect_rsp(input string name, input logic [15:0] d, input logic e, input int exp_wait);
    int waited = 0;
    while (!rsp_valid && waited < 12) begin
      @(negedge clk);
      waited++;
    end
    chk({name, "_latency"}, 32'(waited), 32'(exp_wait));
    chk({name, "_data"}, 32'(rsp_data), 32'(d));
    chk({name, "_err"}, 32'(rsp_err), 32'(e));
    @(negedge clk);
  endtask

  task automatic wait_ready(input string name, input int exp_cycles);
    int n = 0;
    stop();
    @(negedge clk);
    while (!req_ready && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(n), 32'(exp_cycles));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout checks=%0d", n_checks);
    $fatal(1);
  end

  initial begin
    int seen;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0;
    req_addr = '0; req_wdata = '0; req_wstrb = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_data",  32'(rsp_data),  32'd0);
    chk("rst_err",   32'(rsp_err),   32'd0);
    rst_n = 1'b1;
    wait_ready("ready_after_release", EXP_SWEEP);

    // Byte-strobe merge
    issue(1'b1, 'h010, 16'hBEEF, 2'b11);
    issue(1'b1, 'h010, 16'h1234, 2'b10);
    issue(1'b0, 'h010, 16'h0000, 2'b00);
    stop();
    expect_rsp("strb_merge", 16'h12EF, 1'b0, 2);

    // Out-of-range handling at DEPTH boundary
    issue(1'b1, 999,  16'h5A5A, 2'b11);
    issue(1'b1, 1000, 16'hAAAA, 2'b11);
    issue(1'b1, 1023, 16'hAAAA, 2'b11);
    issue(1'b0, 1000, 16'h0000, 2'b00);
    stop();
    expect_rsp("oor_read", 16'h0000, 1'b1, 2);
    issue(1'b0, 999, 16'h0000, 2'b00);
    stop();
    expect_rsp("last_word", 16'h5A5A, 1'b0, 2);

    // Back-to-back reads
    issue(1'b1, 0, 16'h1111, 2'b11);
    issue(1'b1, 1, 16'h2222, 2'b11);
    issue(1'b1, 2, 16'h3333, 2'b11);
    issue(1'b1, 3, 16'h4444, 2'b11);
    issue(1'b0, 0, 16'h0000, 2'b00);
    fork
      begin
        issue(1'b0, 1, 16'h0000, 2'b00);
        issue(1'b0, 2, 16'h0000, 2'b00);
        issue(1'b0, 3, 16'h0000, 2'b00);
        stop();
      end
      begin
        expect_rsp("b2b0", 16'h1111, 1'b0, 2);
        expect_rsp("b2b1", 16'h2222, 1'b0, 0);
        expect_rsp("b2b2", 16'h3333, 1'b0, 0);
        expect_rsp("b2b3", 16'h4444, 1'b0, 0);
      end
    join

    // Reset right after a read is accepted; a write held during reset must be ignored
    issue(1'b0, 'h010, 16'h0000, 2'b00);
    rst_n = 1'b0;
    req_valid = 1'b1; req_we = 1'b1; req_addr = AW'('h010);
    req_wdata = 16'hFFFF; req_wstrb = 2'b11;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    chk("flush_no_rsp", 32'(seen), 32'd0);
    stop();
    rst_n = 1'b1;
    wait_ready("ready_after_flush", EXP_SWEEP);
    issue(1'b0, 'h010, 16'h0000, 2'b00);
    stop();
    expect_rsp("retain_after_rst", RET_AFTER_RST, 1'b0, 2);

`ifdef QX1_RAM_CLEAR_ON_RESET_EN
    // Reset during the sweep restarts it from the beginning
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (31) @(negedge clk);
    chk("mid_sweep_ready", 32'(req_ready), 32'd0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_ready("sweep_restart", 1000);
    issue(1'b0, 0, 16'h0000, 2'b00);
    stop();
    expect_rsp("clear_word0", 16'h0000, 1'b0, 2);
    issue(1'b0, 999, 16'h0000, 2'b00);
    stop();
    expect_rsp("clear_last", 16'h0000, 1'b0, 2);
`endif

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
